vlane_divide: RTL

VLANE_DIVIDE -- requirements
Module: vlane_divide

---
 rtl/vlane_divide.sv | 121 ++++++++++++
 1 files changed

// File: rtl/vlane_divide.sv
// vlane_divide: multi-cycle restoring radix-2 divider (signed/unsigned, quotient or remainder).
// Define VLANE_DIVIDE_ZERO_SHORTCUT_EN to finish zero-dividend / zero-divisor requests in one cycle.
module vlane_divide #(
    parameter int WIDTH     = 32,
    parameter int LOG2WIDTH = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [1:0]       op,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t               state_q, state_d;
    logic [LOG2WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     div_q, div_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 sel_rem_q, sel_rem_d;

    logic                 sgn_a, sgn_b, zero_hit;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       rem_shift, diff;

    assign sgn_a = ~op[1] & opA[WIDTH-1];
    assign sgn_b = ~op[1] & opB[WIDTH-1];
    assign abs_a = sgn_a ? -opA : opA;
    assign abs_b = sgn_b ? -opB : opB;

`ifdef VLANE_DIVIDE_ZERO_SHORTCUT_EN
    assign zero_hit = (opA == '0) | (opB == '0);
`else
    assign zero_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            sel_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            result_q  <= result_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            sel_rem_q <= sel_rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? (zero_hit ? DONE : CALC) : IDLE;
            CALC:    state_d = (cnt_q == LOG2WIDTH'(WIDTH - 1)) ? FIXUP : CALC;
            FIXUP:   state_d = DONE;
            DONE:    state_d = ack ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // The quotient register starts out holding the dividend and shifts quotient bits in from the LSB.
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        result_d  = result_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        sel_rem_d = sel_rem_q;
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, div_q};
        case (state_q)
            IDLE: if (start) begin
                cnt_d     = '0;
                rem_d     = '0;
                quo_d     = abs_a;
                div_d     = abs_b;
                neg_quo_d = (sgn_a ^ sgn_b) & (opB != '0);
                neg_rem_d = sgn_a;
                sel_rem_d = op[0];
                if (zero_hit)
                    result_d = (opB == '0) ? (op[0] ? opA : '1) : '0;
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                rem_d = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            end
            FIXUP:
                result_d = sel_rem_q ? (neg_rem_q ? -rem_q : rem_q) : (neg_quo_q ? -quo_q : quo_q);
            default: ;
        endcase
    end

    always_comb begin
        busy = state_q != IDLE;
        done = state_q == DONE;
    end

    assign result = result_q;
endmodule
